// File: rtl/vane_adc_responder.sv
// vane_adc_responder
// SPI responder standing in for the wind-vane ADC. Each chip-select frame
// returns SAMPLE_CLKS zero bits, a null bit and a DATA_W-bit word, MSB
// first. Data changes on SPICLK falls so the initiator samples on rises.
// SPICLK and nVaneCS are asynchronous and are resynchronised to Clock.
// DATA_W must be at least 2.
module vane_adc_responder #(
    parameter int DATA_W      = 10,
    parameter int SAMPLE_CLKS = 2
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              SPICLK,
    input  logic              nVaneCS,
    input  logic [DATA_W-1:0] sample_in,
    output logic              MISO,
    output logic              miso_oe,
    output logic              frame_done,
    output logic              frame_abort,
    output logic [15:0]       frame_count
);

    localparam int CNT_W = (SAMPLE_CLKS > 1) ? $clog2(SAMPLE_CLKS + 1) : 1;
    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SAMPLE = 3'd1;
    localparam logic [2:0] ST_NULL   = 3'd2;
    localparam logic [2:0] ST_DATA   = 3'd3;
    localparam logic [2:0] ST_TRAIL  = 3'd4;

    // Synchroniser and history registers. CS resets to its idle (high) level.
    logic sclk_meta_reg, sclk_sync_reg, sclk_hist_reg;
    logic cs_meta_reg, cs_sync_reg, cs_hist_reg;

    logic cs_fall, cs_rise, sclk_fall;

    logic [2:0]        state_reg, state_next;
    logic [DATA_W-1:0] shift_reg, shift_next;
    logic [CNT_W-1:0]  fall_cnt_reg, fall_cnt_next;
    logic [IDX_W-1:0]  bit_idx_reg, bit_idx_next;
    logic              bit_val_reg, bit_val_next;
    logic              done_reg, done_next;
    logic              abort_reg, abort_next;
    logic [15:0]       frame_count_reg, frame_count_next;
    logic              miso_reg, miso_oe_reg;

    // Two-flop synchronisers followed by one history stage for edge detection
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            sclk_meta_reg <= 1'b0;
            sclk_sync_reg <= 1'b0;
            sclk_hist_reg <= 1'b0;
            cs_meta_reg   <= 1'b1;
            cs_sync_reg   <= 1'b1;
            cs_hist_reg   <= 1'b1;
        end else begin
            sclk_meta_reg <= SPICLK;
            sclk_sync_reg <= sclk_meta_reg;
            sclk_hist_reg <= sclk_sync_reg;
            cs_meta_reg   <= nVaneCS;
            cs_sync_reg   <= cs_meta_reg;
            cs_hist_reg   <= cs_sync_reg;
        end
    end

    assign cs_fall   = cs_hist_reg & ~cs_sync_reg;
    assign cs_rise   = ~cs_hist_reg & cs_sync_reg;
    assign sclk_fall = sclk_hist_reg & ~sclk_sync_reg;

    // Frame sequencing: CS rise outranks any SCLK fall seen in the same cycle
    always_comb begin
        state_next       = state_reg;
        shift_next       = shift_reg;
        fall_cnt_next    = fall_cnt_reg;
        bit_idx_next     = bit_idx_reg;
        bit_val_next     = bit_val_reg;
        done_next        = 1'b0;
        abort_next       = 1'b0;
        frame_count_next = frame_count_reg;

        if (state_reg == ST_IDLE) begin
            // SCLK is ignored here, which also drops a fall coinciding with CS fall
            if (cs_fall) begin
                shift_next    = sample_in;
                fall_cnt_next = '0;
                bit_val_next  = 1'b0;
                state_next    = (SAMPLE_CLKS == 0) ? ST_NULL : ST_SAMPLE;
            end
        end else if (cs_rise) begin
            state_next   = ST_IDLE;
            bit_val_next = 1'b0;
            // A frame counts as complete once the LSB is on the wire
            if (state_reg == ST_TRAIL ||
                (state_reg == ST_DATA && bit_idx_reg == '0)) begin
                done_next        = 1'b1;
                frame_count_next = frame_count_reg + 16'd1;
            end else begin
                abort_next = 1'b1;
            end
        end else if (sclk_fall) begin
            case (state_reg)
                ST_SAMPLE: begin
                    if (fall_cnt_reg == CNT_W'(SAMPLE_CLKS - 1)) begin
                        state_next   = ST_NULL;
                        bit_val_next = 1'b0;
                    end else begin
                        fall_cnt_next = fall_cnt_reg + 1'b1;
                    end
                end
                ST_NULL: begin
                    bit_val_next = shift_reg[DATA_W-1];
                    bit_idx_next = IDX_W'(DATA_W - 1);
                    state_next   = ST_DATA;
                end
                ST_DATA: begin
                    if (bit_idx_reg == '0) begin
                        state_next   = ST_TRAIL;
                        bit_val_next = 1'b0;
                    end else begin
                        shift_next   = {shift_reg[DATA_W-2:0], 1'b0};
                        bit_val_next = shift_reg[DATA_W-2];
                        bit_idx_next = bit_idx_reg - 1'b1;
                    end
                end
                default: begin
                    // TRAIL: extra clocks after the LSB are ignored
                end
            endcase
        end
    end

    // Frame state registers; reset abandons a frame without any pulse
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_reg       <= ST_IDLE;
            shift_reg       <= '0;
            fall_cnt_reg    <= '0;
            bit_idx_reg     <= '0;
            bit_val_reg     <= 1'b0;
            done_reg        <= 1'b0;
            abort_reg       <= 1'b0;
            frame_count_reg <= '0;
        end else begin
            state_reg       <= state_next;
            shift_reg       <= shift_next;
            fall_cnt_reg    <= fall_cnt_next;
            bit_idx_reg     <= bit_idx_next;
            bit_val_reg     <= bit_val_next;
            done_reg        <= done_next;
            abort_reg       <= abort_next;
            frame_count_reg <= frame_count_next;
        end
    end

    // Pad-facing output stage, one cycle behind the frame state
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            miso_reg    <= 1'b0;
            miso_oe_reg <= 1'b0;
        end else begin
            miso_reg    <= bit_val_reg;
            miso_oe_reg <= (state_reg != ST_IDLE);
        end
    end

    assign MISO        = miso_reg;
    assign miso_oe     = miso_oe_reg;
    assign frame_done  = done_reg;
    assign frame_abort = abort_reg;
    assign frame_count = frame_count_reg;

endmodule

// File: tb/tb_vane_adc_responder.sv
// tb_vane_adc_responder
// Drives SPI frames into vane_adc_responder and checks MISO at every SPICLK
// rise, the done/abort pulses and the frame counter against a reference
// model derived from the frame layout (zeros, null, data MSB first, zeros).
module tb_vane_adc_responder;

    localparam int DATA_W      = 10;
    localparam int SAMPLE_CLKS = 2;
    localparam int PHASE       = 8;

    logic              Clock;
    logic              Reset;
    logic              SPICLK;
    logic              nVaneCS;
    logic [DATA_W-1:0] sample_in;
    logic              MISO;
    logic              miso_oe;
    logic              frame_done;
    logic              frame_abort;
    logic [15:0]       frame_count;

    vane_adc_responder #(.DATA_W(DATA_W), .SAMPLE_CLKS(SAMPLE_CLKS)) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .SPICLK      (SPICLK),
        .nVaneCS     (nVaneCS),
        .sample_in   (sample_in),
        .MISO        (MISO),
        .miso_oe     (miso_oe),
        .frame_done  (frame_done),
        .frame_abort (frame_abort),
        .frame_count (frame_count)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int checks_total = 0;
    int checks_passed = 0;
    int done_cnt = 0;
    int abort_cnt = 0;
    logic [15:0] model_count = 16'h0000;

    typedef struct {
        logic [DATA_W-1:0] val;
        int                pulses;
        int                chg_at;
        logic [DATA_W-1:0] chg_val;
        int                exp_done;
        int                exp_abort;
    } vec_t;

    vec_t vecs[7];

    always @(negedge Clock) begin
        if (frame_done)  done_cnt++;
        if (frame_abort) abort_cnt++;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks_total++;
        if (act == exp) checks_passed++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge Clock);
    endtask

    // Expected MISO at SPICLK rise r (1-based): zeros for the sample phase and
    // the null bit, then the latched word MSB first, then zeros.
    function automatic int model_bit(input logic [DATA_W-1:0] v, input int r);
        int first;
        int k;
        first = SAMPLE_CLKS + 2;
        if (r < first || r >= first + DATA_W) return 0;
        k = DATA_W - 1 - (r - first);
        return int'(v[k]);
    endfunction

    // The frame completes once the falling edge that puts the LSB out has occurred.
    function automatic int model_done(input int pulses);
        return (pulses >= SAMPLE_CLKS + DATA_W) ? 1 : 0;
    endfunction

    task automatic run_frame(input string name, input logic [DATA_W-1:0] val,
                             input int pulses, input int chg_at,
                             input logic [DATA_W-1:0] chg_val,
                             input int exp_done, input int exp_abort);
        int d0;
        int a0;
        int errs0;
        d0 = done_cnt;
        a0 = abort_cnt;
        errs0 = checks_total - checks_passed;
        sample_in = val;
        nVaneCS = 1'b0;
        wait_clks(PHASE);
        for (int p = 1; p <= pulses; p++) begin
            if (p == chg_at) sample_in = chg_val;
            chk($sformatf("%s miso@rise%0d", name, p), int'(MISO), model_bit(val, p));
            if (p == 1) chk($sformatf("%s oe", name), int'(miso_oe), 1);
            SPICLK = 1'b1;
            wait_clks(PHASE);
            SPICLK = 1'b0;
            wait_clks(PHASE);
        end
        nVaneCS = 1'b1;
        wait_clks(6);
        if (exp_done != 0) model_count = model_count + 16'd1;
        chk($sformatf("%s oe_off", name), int'(miso_oe), 0);
        chk($sformatf("%s miso_off", name), int'(MISO), 0);
        chk($sformatf("%s done", name), done_cnt - d0, exp_done);
        chk($sformatf("%s abort", name), abort_cnt - a0, exp_abort);
        chk($sformatf("%s count", name), int'(frame_count), int'(model_count));
        $display("frame %s sample=%h pulses=%0d done=%0d abort=%0d count=%h errors=%0d",
                 name, val, pulses, done_cnt - d0, abort_cnt - a0, frame_count,
                 (checks_total - checks_passed) - errs0);
        wait_clks(4);
    endtask

    initial begin
        Reset = 1'b1;
        SPICLK = 1'b0;
        nVaneCS = 1'b1;
        sample_in = '0;
        wait_clks(3);
        chk("reset miso", int'(MISO), 0);
        chk("reset oe", int'(miso_oe), 0);
        chk("reset done", int'(frame_done), 0);
        chk("reset abort", int'(frame_abort), 0);
        chk("reset count", int'(frame_count), 0);
        Reset = 1'b0;
        wait_clks(4);

        vecs[0] = '{10'h2A5, 13, 0, 10'h000, 1, 0};  // full frame
        vecs[1] = '{10'h3FF,  6, 0, 10'h000, 0, 1};  // abort in data
        vecs[2] = '{10'h001, 13, 6, 10'h3FF, 1, 0};  // mid-frame sample_in change
        vecs[3] = '{10'h2A5, 12, 0, 10'h000, 1, 0};  // CS rise while LSB driven
        vecs[4] = '{10'h2A5, 11, 0, 10'h000, 0, 1};  // CS rise one bit short
        vecs[5] = '{10'h155,  0, 0, 10'h000, 0, 1};  // abort in sample phase
        vecs[6] = '{10'h3FF, 16, 0, 10'h000, 1, 0};  // extra clocks in trail
        for (int i = 0; i < 7; i++) begin
            run_frame($sformatf("vec%0d", i), vecs[i].val, vecs[i].pulses,
                      vecs[i].chg_at, vecs[i].chg_val, vecs[i].exp_done, vecs[i].exp_abort);
        end

        // Idle immunity: SPICLK toggling with CS high
        begin
            int d0;
            int a0;
            int active;
            d0 = done_cnt;
            a0 = abort_cnt;
            active = 0;
            for (int p = 0; p < 20; p++) begin
                SPICLK = 1'b1;
                for (int c = 0; c < PHASE; c++) begin
                    @(negedge Clock);
                    if (MISO || miso_oe) active = 1;
                end
                SPICLK = 1'b0;
                for (int c = 0; c < PHASE; c++) begin
                    @(negedge Clock);
                    if (MISO || miso_oe) active = 1;
                end
            end
            chk("idle active", active, 0);
            chk("idle pulses", (done_cnt - d0) + (abort_cnt - a0), 0);
            $display("idle 20 sclk pulses active=%0d", active);
        end

        // Reset during the data phase
        begin
            int d0;
            int a0;
            d0 = done_cnt;
            a0 = abort_cnt;
            sample_in = 10'h3FF;
            nVaneCS = 1'b0;
            wait_clks(PHASE);
            for (int p = 0; p < 5; p++) begin
                SPICLK = 1'b1;
                wait_clks(PHASE);
                SPICLK = 1'b0;
                wait_clks(PHASE);
            end
            chk("prereset miso", int'(MISO), 1);
            Reset = 1'b1;
            #1;
            chk("midreset outs", int'({MISO, miso_oe, frame_done, frame_abort}), 0);
            chk("midreset count", int'(frame_count), 0);
            model_count = 16'h0000;
            nVaneCS = 1'b1;
            wait_clks(3);
            Reset = 1'b0;
            wait_clks(8);
            chk("midreset pulses", (done_cnt - d0) + (abort_cnt - a0), 0);
            $display("reset mid-frame count=%h", frame_count);
            run_frame("after_reset", 10'h155, 13, 0, 10'h000, 1, 0);
        end

        // Counter wrap
        @(negedge Clock);
        force dut.frame_count_reg = 16'hFFFF;
        @(negedge Clock);
        release dut.frame_count_reg;
        model_count = 16'hFFFF;
        run_frame("wrap", 10'h2A5, 13, 0, 10'h000, 1, 0);

        // Randomised frames against the model
        for (int i = 0; i < 30; i++) begin
            logic [DATA_W-1:0] v;
            logic [DATA_W-1:0] cv;
            int np;
            int ca;
            int ed;
            v  = DATA_W'($urandom_range(0, (1 << DATA_W) - 1));
            cv = DATA_W'($urandom_range(0, (1 << DATA_W) - 1));
            np = $urandom_range(0, 16);
            ca = $urandom_range(0, 14);
            ed = model_done(np);
            run_frame($sformatf("rand%0d", i), v, np, ca, cv, ed, 1 - ed);
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
